// File: rtl/l1_dcache_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l1_dcache_wb_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate L1 data cache
//            controller with line-wide memory port and whole-cache flush.
// Revision : 1.0 - initial release
// ============================================================================
module l1_dcache_wb_ctrl #(
    parameter int LINE_BYTES = 32,
    parameter int NUM_LINES  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_ack,
    input  logic                      flush_req,
    output logic                      flush_done,
    input  logic [8*LINE_BYTES-1:0]   mem_data_i,
    input  logic                      mem_ack,
    output logic [8*LINE_BYTES-1:0]   mem_data_o,
    output logic [31:0]               mem_addr,
    output logic                      mem_cs,
    output logic                      mem_we
);

    localparam int LW  = 8 * LINE_BYTES;
    localparam int OFF = $clog2(LINE_BYTES);
    localparam int IDX = $clog2(NUM_LINES);
    localparam int TAG = 32 - OFF - IDX;
    localparam int WSW = OFF - 2;

    localparam logic [IDX:0] c_CNT_LAST = (IDX+1)'(NUM_LINES - 1);
    localparam logic [IDX:0] c_CNT_ONE  = (IDX+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COMPARE    = 3'd1,
        S_WRITE_BACK = 3'd2,
        S_ALLOCATE   = 3'd3,
        S_FLUSH_SCAN = 3'd4,
        S_FLUSH_WB   = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_we;
    logic [31:2]          r_addr;
    logic [31:0]          r_wdata;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [IDX:0]         r_cnt;
    logic [TAG-1:0]       r_tag_arr  [NUM_LINES];
    logic [LW-1:0]        r_data_arr [NUM_LINES];

    logic [IDX-1:0] w_idx;
    logic [TAG-1:0] w_tag;
    logic [WSW-1:0] w_wsel;
    logic [IDX-1:0] w_fidx;
    logic           w_hit;
    logic           w_fdirty;
    logic           w_flast;
    logic [LW-1:0]  w_line;
    logic [LW-1:0]  w_merged;
    logic [31:0]    w_word;
    logic           w_store_hit;
    logic           w_refill;
    logic [1:0]     w_unused_lsb;

    // Byte-lane bits of the CPU address carry no meaning for word accesses
    assign w_unused_lsb = cpu_addr[1:0];

    assign w_idx    = r_addr[OFF+IDX-1:OFF];
    assign w_tag    = r_addr[31:OFF+IDX];
    assign w_wsel   = r_addr[OFF-1:2];
    assign w_fidx   = r_cnt[IDX-1:0];
    assign w_hit    = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_line   = r_data_arr[w_idx];
    assign w_word   = w_line[{w_wsel, 5'b0} +: 32];
    assign w_fdirty = r_valid[w_fidx] && r_dirty[w_fidx];
    assign w_flast  = (r_cnt == c_CNT_LAST);

    assign w_store_hit = (r_state == S_COMPARE) && w_hit && r_we;
    assign w_refill    = (r_state == S_ALLOCATE) && mem_cs && mem_ack;

    // Current line with the store word substituted at the selected position
    always_comb begin
        w_merged = w_line;
        w_merged[{w_wsel, 5'b0} +: 32] = r_wdata;
    end

    // Tag and data storage: written on store hits and line refills, never reset
    always_ff @(posedge clk) begin
        if (w_refill) begin
            r_data_arr[w_idx] <= mem_data_i;
            r_tag_arr[w_idx]  <= w_tag;
        end else if (w_store_hit) begin
            r_data_arr[w_idx] <= w_merged;
        end
    end

    // Control FSM with registered CPU and memory-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_cnt      <= '0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
            flush_done <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data_o <= '0;
        end else begin
            cpu_ack    <= 1'b0;
            flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Flush has priority; a concurrent CPU request stays pending
                    if (flush_req) begin
                        r_cnt   <= '0;
                        r_state <= S_FLUSH_SCAN;
                    end else if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr[31:2];
                        r_wdata <= cpu_wdata;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        if (r_we) begin
                            r_dirty[w_idx] <= 1'b1;
                        end else begin
                            cpu_rdata <= w_word;
                        end
                        cpu_ack <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        mem_cs     <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_addr   <= {r_tag_arr[w_idx], w_idx, {OFF{1'b0}}};
                        mem_data_o <= w_line;
                        r_state    <= S_WRITE_BACK;
                    end else begin
                        mem_cs   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {w_tag, w_idx, {OFF{1'b0}}};
                        r_state  <= S_ALLOCATE;
                    end
                end
                S_WRITE_BACK: begin
                    // The refill request is issued straight from the write-back ack
                    if (mem_cs && mem_ack) begin
                        r_dirty[w_idx] <= 1'b0;
                        mem_we         <= 1'b0;
                        mem_addr       <= {w_tag, w_idx, {OFF{1'b0}}};
                        r_state        <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_cs && mem_ack) begin
                        mem_cs         <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= S_COMPARE;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (w_fdirty) begin
                        mem_cs     <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_addr   <= {r_tag_arr[w_fidx], w_fidx, {OFF{1'b0}}};
                        mem_data_o <= r_data_arr[w_fidx];
                        r_state    <= S_FLUSH_WB;
                    end else if (w_flast) begin
                        flush_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_FLUSH_WB: begin
                    if (mem_cs && mem_ack) begin
                        mem_cs          <= 1'b0;
                        mem_we          <= 1'b0;
                        r_dirty[w_fidx] <= 1'b0;
                        if (w_flast) begin
                            flush_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + c_CNT_ONE;
                            r_state <= S_FLUSH_SCAN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_dcache_wb_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_l1_dcache_wb_ctrl
// Purpose  : Scoreboard bench for l1_dcache_wb_ctrl in the default (32B x 32)
//            and a small (16B x 8) configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_dcache_wb_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpu_req, cpu_we, flush_req;
    logic [1:0]  mem_ack = 2'b00;
    logic [31:0] cpu_addr [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic [1:0]  cpu_ack, flush_done, mem_cs, mem_we;
    logic [31:0] mem_addr [2];
    logic [255:0] mdi0, mdo0;
    logic [127:0] mdi1, mdo1;

    typedef struct {
        int          s;
        logic        we;
        logic [31:0] addr;
        int          widx;
        logic [31:0] wval;
        logic        cw;
    } txn_t;

    txn_t        exp_txn[$];
    logic [31:0] exp_rd[$];
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    l1_dcache_wb_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
        .flush_req(flush_req[0]), .flush_done(flush_done[0]),
        .mem_data_i(mdi0), .mem_ack(mem_ack[0]), .mem_data_o(mdo0),
        .mem_addr(mem_addr[0]), .mem_cs(mem_cs[0]), .mem_we(mem_we[0])
    );

    l1_dcache_wb_ctrl #(.LINE_BYTES(16), .NUM_LINES(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
        .flush_req(flush_req[1]), .flush_done(flush_done[1]),
        .mem_data_i(mdi1), .mem_ack(mem_ack[1]), .mem_data_o(mdo1),
        .mem_addr(mem_addr[1]), .mem_cs(mem_cs[1]), .mem_we(mem_we[1])
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wkey(input int s, input logic [31:0] a);
        return {s[0], a[31:2], 1'b0};
    endfunction

    function automatic logic [31:0] init_word(input int s, input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ (s << 28);
    endfunction

    function automatic logic [31:0] bword(input int s, input logic [31:0] a);
        logic [31:0] k;
        k = wkey(s, a);
        return bmem.exists(k) ? bmem[k] : init_word(s, a);
    endfunction

    function automatic logic [31:0] rword(input int s, input logic [31:0] a);
        logic [31:0] k;
        k = wkey(s, a);
        return rmem.exists(k) ? rmem[k] : init_word(s, a);
    endfunction

    task automatic push_txn(input int s, input logic we, input logic [31:0] a,
                            input int widx, input logic [31:0] wv, input logic cw);
        txn_t t;
        t.s = s; t.we = we; t.addr = a; t.widx = widx; t.wval = wv; t.cw = cw;
        exp_txn.push_back(t);
    endtask

    // Line memory: acks LAT cycles after mem_cs rises, checks order against exp_txn
    always @(negedge clk) begin : p_mem
        logic [255:0] line;
        logic [255:0] rl;
        logic [31:0]  a;
        int           wpl;
        txn_t         e;
        for (int s = 0; s < 2; s++) begin
            if (mem_ack[s]) begin
                mem_ack[s] = 1'b0;
                cnt[s] = 0;
            end
            if (!mem_cs[s]) begin
                cnt[s] = 0;
            end else begin
                cnt[s]++;
                if (cnt[s] == LAT + 1) begin
                    a    = mem_addr[s];
                    wpl  = (s == 0) ? 8 : 4;
                    line = (s == 0) ? mdo0 : {128'b0, mdo1};
                    if (exp_txn.size() == 0) begin
                        chk_eq("mem_unexpected_txn", {31'b0, mem_we[s], a}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_txn.pop_front();
                        chk_eq("mem_inst", 64'(s), 64'(e.s));
                        chk_eq("mem_we", mem_we[s], e.we);
                        chk_eq("mem_addr", a, e.addr);
                        if (e.cw) chk_eq("mem_wdata", line[e.widx*32 +: 32], e.wval);
                    end
                    if (mem_we[s]) begin
                        for (int w = 0; w < wpl; w++) bmem[wkey(s, a + 4*w)] = line[w*32 +: 32];
                    end else begin
                        rl = '0;
                        for (int w = 0; w < wpl; w++) rl[w*32 +: 32] = bword(s, a + 4*w);
                        if (s == 0) mdi0 = rl; else mdi1 = rl[127:0];
                    end
                    mem_ack[s] = 1'b1;
                end
            end
        end
    end

    task automatic cpu_access(input int s, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input int exp_lat);
        int n;
        logic got;
        if (we) rmem[wkey(s, a)] = wd;
        else    exp_rd.push_back(rword(s, a));
        cpu_we[s] = we; cpu_addr[s] = a; cpu_wdata[s] = wd; cpu_req[s] = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (cpu_ack[s]) got = 1'b1;
        end
        cpu_req[s] = 1'b0;
        chk_eq($sformatf("ack_seen_%0h", a), got, 1);
        if (!we) chk_eq($sformatf("load_%0h", a), cpu_rdata[s], exp_rd.pop_front());
        chk_eq($sformatf("latency_%0h", a), 64'(n), 64'(exp_lat));
        @(posedge clk); @(negedge clk);
        chk_eq("ack_pulse", cpu_ack[s], 0);
    endtask

    task automatic do_flush(input int s);
        int n;
        int pulses;
        logic got;
        flush_req[s] = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 600) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (flush_done[s]) begin
                got = 1'b1;
                chk_eq("ack_with_flush_done", cpu_ack[s], 0);
            end
        end
        flush_req[s] = 1'b0;
        chk_eq("flush_done_seen", got, 1);
        pulses = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (flush_done[s]) pulses++;
        end
        chk_eq("flush_done_extra", 64'(pulses), 0);
        chk_eq("flush_txn_left", 64'(exp_txn.size()), 0);
    endtask

    initial begin : p_wdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int n, fd_cyc, ack_cyc;
        logic seen;
        rst = 1'b0;
        cpu_req = '0; cpu_we = '0; flush_req = '0;
        cpu_addr  = '{32'h0, 32'h0};
        cpu_wdata = '{32'h0, 32'h0};
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk_eq("rst_cpu_ack", cpu_ack[s], 0);
            chk_eq("rst_flush_done", flush_done[s], 0);
            chk_eq("rst_mem_cs", mem_cs[s], 0);
            chk_eq("rst_mem_we", mem_we[s], 0);
            chk_eq("rst_mem_addr", mem_addr[s], 0);
            chk_eq("rst_cpu_rdata", cpu_rdata[s], 0);
        end
        chk_eq("rst_mem_data_o", mdo0[63:0] | mdo0[255:192], 0);
        chk_eq("rst_valid", u_dut0.r_valid, 0);
        chk_eq("rst_dirty", u_dut0.r_dirty, 0);
        rst = 1'b1;
        @(negedge clk);

        // cold load, then hit
        push_txn(0, 1'b0, 32'h40, 0, 0, 1'b0);
        cpu_access(0, 1'b0, 32'h40, 0, 7);
        cpu_access(0, 1'b0, 32'h40, 0, 2);

        // store hit, load back, dirty bit
        cpu_access(0, 1'b1, 32'h44, 32'hDEADBEEF, 2);
        cpu_access(0, 1'b0, 32'h44, 0, 2);
        chk_eq("dirty_idx2", u_dut0.r_dirty[2], 1);

        // dirty conflict miss: write-back then refill
        push_txn(0, 1'b1, 32'h40, 1, 32'hDEADBEEF, 1'b1);
        push_txn(0, 1'b0, 32'h440, 0, 0, 1'b0);
        cpu_access(0, 1'b0, 32'h444, 0, 11);
        chk_eq("evict_txn_left", 64'(exp_txn.size()), 0);

        // dirty lines 0, 5, 31 then flush
        push_txn(0, 1'b0, 32'h0, 0, 0, 1'b0);
        cpu_access(0, 1'b1, 32'h0, 32'hA0A0_0001, 7);
        push_txn(0, 1'b0, 32'hA0, 0, 0, 1'b0);
        cpu_access(0, 1'b1, 32'hA8, 32'hB5B5_0002, 7);
        push_txn(0, 1'b0, 32'h3E0, 0, 0, 1'b0);
        cpu_access(0, 1'b1, 32'h3FC, 32'hC3C3_0003, 7);
        push_txn(0, 1'b1, 32'h0, 0, 32'hA0A0_0001, 1'b1);
        push_txn(0, 1'b1, 32'hA0, 2, 32'hB5B5_0002, 1'b1);
        push_txn(0, 1'b1, 32'h3E0, 7, 32'hC3C3_0003, 1'b1);
        do_flush(0);
        chk_eq("flush_dirty_clear", u_dut0.r_dirty, 0);
        cpu_access(0, 1'b0, 32'h3FC, 0, 2);

        // simultaneous flush_req and cpu_req: flush first
        push_txn(0, 1'b0, 32'h100, 0, 0, 1'b0);
        cpu_access(0, 1'b1, 32'h104, 32'h1111_2222, 7);
        push_txn(0, 1'b1, 32'h100, 1, 32'h1111_2222, 1'b1);
        exp_rd.push_back(rword(0, 32'h104));
        flush_req[0] = 1'b1;
        cpu_we[0] = 1'b0; cpu_addr[0] = 32'h104; cpu_req[0] = 1'b1;
        n = 0; fd_cyc = -1; ack_cyc = -1;
        while ((fd_cyc < 0 || ack_cyc < 0) && n < 300) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (flush_done[0] && fd_cyc < 0) begin
                fd_cyc = n;
                flush_req[0] = 1'b0;
            end
            if (cpu_ack[0] && ack_cyc < 0) begin
                ack_cyc = n;
                cpu_req[0] = 1'b0;
                chk_eq("race_load", cpu_rdata[0], exp_rd.pop_front());
            end
        end
        flush_req[0] = 1'b0; cpu_req[0] = 1'b0;
        chk_eq("race_flush_seen", fd_cyc > 0, 1);
        chk_eq("race_ack_seen", ack_cyc > 0, 1);
        chk_eq("race_flush_first", fd_cyc < ack_cyc, 1);
        chk_eq("race_txn_left", 64'(exp_txn.size()), 0);
        @(negedge clk);

        // reset while a refill is outstanding
        cpu_we[0] = 1'b0; cpu_addr[0] = 32'h800; cpu_req[0] = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (mem_cs[0]) seen = 1'b1;
        end
        chk_eq("alloc_cs_seen", seen, 1);
        chk_eq("alloc_cs_read", mem_we[0], 0);
        #2 rst = 1'b0;
        #1 chk_eq("async_rst_cs", mem_cs[0], 0);
        cpu_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_valid_again", u_dut0.r_valid, 0);
        push_txn(0, 1'b0, 32'h800, 0, 0, 1'b0);
        cpu_access(0, 1'b0, 32'h800, 0, 7);

        // small configuration: 16-byte lines, 8 lines
        push_txn(1, 1'b0, 32'h40, 0, 0, 1'b0);
        cpu_access(1, 1'b0, 32'h40, 0, 7);
        cpu_access(1, 1'b0, 32'h44, 0, 2);
        push_txn(1, 1'b0, 32'h0, 0, 0, 1'b0);
        cpu_access(1, 1'b1, 32'h0, 32'h5151_0000, 7);
        push_txn(1, 1'b0, 32'h50, 0, 0, 1'b0);
        cpu_access(1, 1'b1, 32'h58, 32'h5252_0005, 7);
        push_txn(1, 1'b0, 32'h70, 0, 0, 1'b0);
        cpu_access(1, 1'b1, 32'h7C, 32'h5353_0007, 7);
        push_txn(1, 1'b1, 32'h0, 0, 32'h5151_0000, 1'b1);
        push_txn(1, 1'b1, 32'h50, 2, 32'h5252_0005, 1'b1);
        push_txn(1, 1'b1, 32'h70, 3, 32'h5353_0007, 1'b1);
        do_flush(1);
        chk_eq("small_dirty_clear", u_dut1.r_dirty, 0);
        cpu_access(1, 1'b0, 32'h7C, 0, 2);

        repeat (3) @(negedge clk);
        chk_eq("final_txn_left", 64'(exp_txn.size()), 0);
        chk_eq("final_rd_left", 64'(exp_rd.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
